// File: rtl/nv_nvdla_pdp_rdma_pkg.sv
// Shared definitions for the PDP RDMA context queue.
// Provides the default parameter values and the width helpers that size the
// credit counter and occupancy ports.
package nv_nvdla_pdp_rdma_pkg;

  localparam int CTXQ_DEPTH   = 16;
  localparam int CTXQ_PD_W    = 18;
  localparam int CTXQ_CREDITS = 64;
  localparam int CTXQ_BEAT_W  = 3;

  // Width that holds every value 0..credits.
  function automatic int cdt_cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction

  // Width that holds every occupancy value 0..depth.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_rdma_ctxq_if.sv
// Context handshake bundle: ingress push (ig2cq_*) and egress pop (cq2eg_*).
//   slave  : the context queue side (accepts pushes, presents pops)
//   master : the ingress/egress side driving the queue
interface nv_nvdla_pdp_rdma_ctxq_if
  import nv_nvdla_pdp_rdma_pkg::*;
#(
  parameter int PD_W = CTXQ_PD_W
);
  logic            ig2cq_pvld;
  logic            ig2cq_prdy;
  logic [PD_W-1:0] ig2cq_pd;
  logic            cq2eg_pvld;
  logic            cq2eg_prdy;
  logic [PD_W-1:0] cq2eg_pd;

  modport slave (
    input  ig2cq_pvld, ig2cq_pd, cq2eg_prdy,
    output ig2cq_prdy, cq2eg_pvld, cq2eg_pd
  );

  modport master (
    output ig2cq_pvld, ig2cq_pd, cq2eg_prdy,
    input  ig2cq_prdy, cq2eg_pvld, cq2eg_pd
  );
endinterface

// File: rtl/nv_nvdla_pdp_rdma_ctxq_fifo.sv
// Context storage: flop array with a registered head-of-queue output.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_pd     write request (caller guarantees not full)
//   pop               consume the presented head entry
//   flush             synchronous clear of pointers and occupancy
//   out_vld, out_pd   registered head entry
//   occupancy         registered number of valid entries
module nv_nvdla_pdp_rdma_ctxq_fifo
  import nv_nvdla_pdp_rdma_pkg::*;
#(
  parameter  int DEPTH = CTXQ_DEPTH,
  parameter  int PD_W  = CTXQ_PD_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int OW    = occ_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [PD_W-1:0] push_pd,
  input  logic            pop,
  input  logic            flush,
  output logic            out_vld,
  output logic [PD_W-1:0] out_pd,
  output logic [OW-1:0]   occupancy
);

  logic [PD_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [OW-1:0]   cnt_nxt;
  logic            do_push, do_pop, forward;

  assign do_push = push && !flush;
  assign do_pop  = pop && out_vld && !flush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_ptr_nxt = rd_ptr + AW'(do_pop);
    wr_ptr_nxt = wr_ptr + AW'(do_push);
    cnt_nxt    = occupancy + OW'(do_push) - OW'(do_pop);
    // The next head is the slot being written this cycle only when the queue
    // would otherwise be empty; forward the input so it appears next cycle.
    forward    = do_push && ((occupancy - OW'(do_pop)) == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      out_vld   <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      out_vld   <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      occupancy <= cnt_nxt;
      out_vld   <= (cnt_nxt != '0);
    end
  end

  // NOTE: storage and the data register carry no reset; validity is tracked by out_vld/occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_pd;
    out_pd <= forward ? push_pd : mem[rd_ptr_nxt];
  end

endmodule

// File: rtl/nv_nvdla_pdp_rdma_ctxq.sv
// PDP RDMA context queue with read-credit tracking and ingress-stall counter.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn   clock, async active-low reset
//   ctxq (slave)                      ig2cq push / cq2eg pop handshakes
//   rd_req_fire, rd_req_beats         accepted read request and its beat count
//   cdt_lat_fifo_pop                  one latency-FIFO entry returned
//   credit_ok, credit_cnt, credit_err worst-case-issuable flag, free credits, sticky error
//   flush, occupancy                  queue clear, valid entry count
//   perf_en, perf_clr, perf_stall_cnt ingress-stall performance counter
module nv_nvdla_pdp_rdma_ctxq
  import nv_nvdla_pdp_rdma_pkg::*;
#(
  parameter  int DEPTH   = CTXQ_DEPTH,
  parameter  int PD_W    = CTXQ_PD_W,
  parameter  int CREDITS = CTXQ_CREDITS,
  parameter  int BEAT_W  = CTXQ_BEAT_W,
  localparam int CW      = cdt_cnt_w(CREDITS),
  localparam int OW      = occ_w(DEPTH)
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  nv_nvdla_pdp_rdma_ctxq_if.slave  ctxq,
  input  logic                     rd_req_fire,
  input  logic [BEAT_W-1:0]        rd_req_beats,
  input  logic                     cdt_lat_fifo_pop,
  output logic                     credit_ok,
  output logic [CW-1:0]            credit_cnt,
  input  logic                     flush,
  output logic [OW-1:0]            occupancy,
  input  logic                     perf_en,
  input  logic                     perf_clr,
  output logic [31:0]              perf_stall_cnt,
  output logic                     credit_err
);

  // Arithmetic width wide enough for credits, beats and one carry bit.
  localparam int MW = ((CW > BEAT_W) ? CW : BEAT_W) + 1;

  logic          full, push, pop, stall;
  logic [MW-1:0] avail, consume, diff;
  logic [CW-1:0] credit_nxt;
  logic          err_set;

  // No bypass: a pop in the same cycle does not open a full queue.
  assign full            = (occupancy == OW'(DEPTH));
  assign ctxq.ig2cq_prdy = !full && !flush;
  assign push            = ctxq.ig2cq_pvld && ctxq.ig2cq_prdy;
  assign pop             = ctxq.cq2eg_pvld && ctxq.cq2eg_prdy;

  nv_nvdla_pdp_rdma_ctxq_fifo #(
    .DEPTH (DEPTH),
    .PD_W  (PD_W)
  ) u_fifo (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .push      (push),
    .push_pd   (ctxq.ig2cq_pd),
    .pop       (pop),
    .flush     (flush),
    .out_vld   (ctxq.cq2eg_pvld),
    .out_pd    (ctxq.cq2eg_pd),
    .occupancy (occupancy)
  );

  // Consume and return are netted in one cycle, then clamped to 0..CREDITS.
  always_comb begin
    avail      = MW'(credit_cnt) + MW'(cdt_lat_fifo_pop);
    consume    = rd_req_fire ? MW'(rd_req_beats) : '0;
    diff       = avail - consume;
    credit_nxt = CW'(diff);
    err_set    = 1'b0;
    if (consume > avail) begin
      credit_nxt = '0;
      err_set    = 1'b1;
    end else if (diff > MW'(CREDITS)) begin
      credit_nxt = CW'(CREDITS);
      err_set    = 1'b1;
    end
  end

  assign credit_ok = (MW'(credit_cnt) >= MW'((1 << BEAT_W) - 1));
  assign stall     = ctxq.ig2cq_pvld && !ctxq.ig2cq_prdy && perf_en;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      credit_cnt     <= CW'(CREDITS);
      credit_err     <= 1'b0;
      perf_stall_cnt <= '0;
    end else begin
      credit_cnt <= credit_nxt;
      if (err_set) credit_err <= 1'b1;
      if (perf_clr)
        perf_stall_cnt <= '0;
      else if (stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end

endmodule
